// File: rtl/klp32_dbg_pkg.sv
// Shared types for the KLP32 debug run controller: host command opcodes, halt causes, FSM states.
package klp32_dbg_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_HALT    = 3'd1,
        CMD_RUN     = 3'd2,
        CMD_STEP    = 3'd3,
        CMD_SET_BP  = 3'd4,
        CMD_CLR_BP  = 3'd5,
        CMD_CLR_CNT = 3'd6
    } cmd_op_t;

    // Five distinct causes, so the encoding needs three bits.
    typedef enum logic [2:0] {
        CAUSE_RESET  = 3'd0,
        CAUSE_BP     = 3'd1,
        CAUSE_EBREAK = 3'd2,
        CAUSE_STEP   = 3'd3,
        CAUSE_HOST   = 3'd4
    } halt_cause_t;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } run_state_t;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/klp32_run_ctrl_bp_match.sv
// PC breakpoint slots (valid + word address), written by host commands; combinational hit.
module bp_match
    import klp32_dbg_pkg::*;
#(
    parameter int NUM_BP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        setEn,
    input  logic        clrEn,
    input  logic [2:0]  idx,
    input  logic [29:0] addr,
    input  logic [29:0] pcWord,
    output logic        hit
);

    logic [NUM_BP-1:0] slotVld;
    logic [29:0]       slotAddr [NUM_BP];

    // Indices at or above NUM_BP match no slot, so such commands fall through silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            slotVld <= '0;
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (idx == 3'(i)) begin
                    if (setEn) begin
                        slotVld[i]  <= 1'b1;
                        slotAddr[i] <= addr;
                    end else if (clrEn) begin
                        slotVld[i]  <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (slotVld[i] && (slotAddr[i] == pcWord)) hit = 1'b1;
        end
    end

endmodule

// File: rtl/klp32_run_ctrl.sv
// Run/halt/step sequencer for the KLP32 core: gates commits, halts on breakpoint/EBREAK/host,
// counts retired instructions.
module klp32_run_ctrl
    import klp32_dbg_pkg::*;
#(
    parameter int NUM_BP       = 4,
    parameter int CNT_W        = 32,
    parameter bit START_HALTED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_inst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [2:0]       i_cmd_idx,
    input  logic [31:0]      i_cmd_arg,
    output logic             o_core_en,
    output logic             o_halted,
    output logic             o_halt_evt,
    output logic [2:0]       o_halt_cause,
    output logic [CNT_W-1:0] o_retired
);

    run_state_t  state, stateNxt;
    halt_cause_t cause, causeNxt;
    logic        skip, skipNxt;
    logic [31:0] stepCnt, stepCntNxt;
    logic        cmdTake, hit, ebrk, stopReq;
    logic [1:0]  unusedPcLsb;

    assign unusedPcLsb  = i_pc[1:0];
    assign o_cmd_ready  = (state != ST_STEPPING);
    assign cmdTake      = i_cmd_valid && o_cmd_ready;
    assign ebrk         = (i_inst == EBREAK_INST);
    // skip lets the instruction we halted on commit once when resuming.
    assign stopReq      = (hit || ebrk) && !skip;
    assign o_halted     = (state == ST_HALTED);
    assign o_halt_cause = cause;

    bp_match #(.NUM_BP(NUM_BP)) u_bp_match (
        .clk    (clk),
        .reset  (reset),
        .setEn  (cmdTake && (i_cmd_op == CMD_SET_BP)),
        .clrEn  (cmdTake && (i_cmd_op == CMD_CLR_BP)),
        .idx    (i_cmd_idx),
        .addr   (i_cmd_arg[31:2]),
        .pcWord (i_pc[31:2]),
        .hit    (hit)
    );

    always_comb begin
        stateNxt   = state;
        causeNxt   = cause;
        skipNxt    = skip;
        stepCntNxt = stepCnt;
        o_core_en  = 1'b0;
        case (state)
            ST_HALTED: begin
                if (cmdTake && (i_cmd_op == CMD_RUN)) begin
                    stateNxt = ST_RUNNING;
                    skipNxt  = 1'b1;
                end else if (cmdTake && (i_cmd_op == CMD_STEP)) begin
                    stateNxt   = ST_STEPPING;
                    stepCntNxt = (i_cmd_arg == 32'd0) ? 32'd1 : i_cmd_arg;
                end
            end
            ST_RUNNING: begin
                o_core_en = !stopReq;
                if (stopReq) begin
                    stateNxt = ST_HALTED;
                    causeNxt = hit ? CAUSE_BP : CAUSE_EBREAK;
                end else if (cmdTake && (i_cmd_op == CMD_HALT)) begin
                    stateNxt = ST_HALTED;
                    causeNxt = CAUSE_HOST;
                end
            end
            ST_STEPPING: begin
                o_core_en  = 1'b1;
                stepCntNxt = stepCnt - 32'd1;
                if (stepCnt == 32'd1) begin
                    stateNxt = ST_HALTED;
                    causeNxt = CAUSE_STEP;
                end
            end
            default: stateNxt = ST_HALTED;
        endcase
        if (o_core_en) skipNxt = 1'b0;
        if (reset) o_core_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= START_HALTED ? ST_HALTED : ST_RUNNING;
            cause      <= CAUSE_RESET;
            skip       <= 1'b0;
            stepCnt    <= 32'd0;
            o_halt_evt <= 1'b0;
            o_retired  <= '0;
        end else begin
            state      <= stateNxt;
            cause      <= causeNxt;
            skip       <= skipNxt;
            stepCnt    <= stepCntNxt;
            o_halt_evt <= (stateNxt == ST_HALTED) && (state != ST_HALTED);
            if (cmdTake && (i_cmd_op == CMD_CLR_CNT)) o_retired <= '0;
            else if (o_core_en)                       o_retired <= o_retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_klp32_run_ctrl.sv
// Bench for klp32_run_ctrl: directed scenarios plus random traffic, all checked each cycle against a reference model.
module tb_klp32_run_ctrl;
    import klp32_dbg_pkg::*;

    localparam int NBP    = 4;
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_pc = '0, i_inst = '0, i_cmd_arg = '0;
    logic        i_cmd_valid = 1'b0;
    logic [2:0]  i_cmd_op = '0, i_cmd_idx = '0;
    logic        o_cmd_ready, o_core_en, o_halted, o_halt_evt;
    logic [2:0]  o_halt_cause;
    logic [31:0] o_retired;

    always #5 clk = ~clk;

    klp32_run_ctrl dut (
        .clk(clk), .reset(reset), .i_pc(i_pc), .i_inst(i_inst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_idx(i_cmd_idx), .i_cmd_arg(i_cmd_arg), .o_core_en(o_core_en),
        .o_halted(o_halted), .o_halt_evt(o_halt_evt), .o_halt_cause(o_halt_cause),
        .o_retired(o_retired)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: debugger-level view of the controller
    bit          mValid = 0;
    int          mMode;
    bit          mSkip;
    int unsigned mLeft;
    int unsigned mRet;
    halt_cause_t mCause;
    bit          mEvt;
    bit          mBpV [NBP];
    int unsigned mBpA [NBP];
    bit          lastEn;
    logic [31:0] curPc = '0;

    task automatic mReset();
        mValid = 1; mMode = M_HALT; mSkip = 0; mLeft = 0; mRet = 0;
        mCause = CAUSE_RESET; mEvt = 0;
        for (int i = 0; i < NBP; i++) begin mBpV[i] = 0; mBpA[i] = 0; end
    endtask

    function automatic bit mHit(input logic [31:0] pc);
        for (int i = 0; i < NBP; i++)
            if (mBpV[i] && (mBpA[i] == (pc >> 2))) return 1;
        return 0;
    endfunction

    task automatic cyc(input bit rst, input bit v, input logic [2:0] op, input logic [2:0] idx,
                       input logic [31:0] arg, input logic [31:0] pc, input logic [31:0] inst);
        bit hit, stop, en, take, wasHalted;
        @(negedge clk);
        reset = rst; i_cmd_valid = v; i_cmd_op = op; i_cmd_idx = idx;
        i_cmd_arg = arg; i_pc = pc; i_inst = inst;
        #1;
        hit  = mHit(pc);
        stop = hit || (inst == 32'h0010_0073);
        en   = !rst && mValid && ((mMode == M_RUN) ? !(stop && !mSkip) : (mMode == M_STEP));
        chk("core_en", 32'(o_core_en), 32'(en));
        if (mValid) begin
            chk("cmd_ready", 32'(o_cmd_ready), 32'(mMode != M_STEP));
            chk("halted", 32'(o_halted), 32'(mMode == M_HALT));
            chk("halt_evt", 32'(o_halt_evt), 32'(mEvt));
            chk("halt_cause", 32'(o_halt_cause), 32'(mCause));
            chk("retired", o_retired, mRet);
        end
        lastEn = en;
        if (rst) begin
            mReset();
        end else if (mValid) begin
            take = v && (mMode != M_STEP);
            wasHalted = (mMode == M_HALT);
            if (take && op == CMD_CLR_CNT) mRet = 0;
            else if (en) mRet++;
            if (take && op == CMD_SET_BP && idx < NBP) begin
                mBpV[idx] = 1; mBpA[idx] = arg >> 2;
            end
            if (take && op == CMD_CLR_BP && idx < NBP) mBpV[idx] = 0;
            case (mMode)
                M_HALT: begin
                    if (take && op == CMD_RUN) begin mMode = M_RUN; mSkip = 1; end
                    else if (take && op == CMD_STEP) begin
                        mMode = M_STEP; mLeft = (arg == 0) ? 1 : arg;
                    end
                end
                M_RUN: begin
                    if (stop && !mSkip) begin
                        mMode = M_HALT; mCause = hit ? CAUSE_BP : CAUSE_EBREAK;
                    end else if (take && op == CMD_HALT) begin
                        mMode = M_HALT; mCause = CAUSE_HOST;
                    end
                    if (en) mSkip = 0;
                end
                default: begin
                    mLeft--;
                    if (mLeft == 0) begin mMode = M_HALT; mCause = CAUSE_STEP; end
                end
            endcase
            mEvt = !wasHalted && (mMode == M_HALT);
        end
    endtask

    // One cycle of a core that advances its PC whenever an instruction commits.
    task automatic tick(input bit v, input logic [2:0] op, input logic [31:0] arg, input logic [31:0] inst);
        cyc(0, v, op, 3'd0, arg, curPc, inst);
        if (lastEn) curPc += 4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, CMD_NOP, 0, 32'h13);
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    initial begin
        int guard;
        cyc(1, 0, CMD_NOP, 0, 0, 0, 32'h13);
        cyc(1, 0, CMD_NOP, 0, 0, 0, 32'h13);
        idle(5);
        settle();
        chk("rst_core_en", 32'(o_core_en), 0);
        chk("rst_halted", 32'(o_halted), 1);
        chk("rst_cause", 32'(o_halt_cause), 32'(CAUSE_RESET));
        chk("rst_retired", o_retired, 0);
        chk("rst_evt", 32'(o_halt_evt), 0);

        tick(1, CMD_STEP, 3, 32'h13);
        idle(2);
        chk("step_ready_low", 32'(o_cmd_ready), 0);
        idle(3);
        settle();
        chk("step3_retired", o_retired, 3);
        chk("step3_cause", 32'(o_halt_cause), 32'(CAUSE_STEP));

        curPc = 0;
        cyc(0, 1, CMD_SET_BP, 3'd0, 32'h40, curPc, 32'h13);
        tick(1, CMD_RUN, 0, 32'h13);
        guard = 0;
        while (mMode != M_HALT && guard < 40) begin idle(1); guard++; end
        chk("bp_timeout", 32'(guard < 40), 1);
        settle();
        chk("bp_halted", 32'(o_halted), 1);
        chk("bp_cause", 32'(o_halt_cause), 32'(CAUSE_BP));
        chk("bp_retired", o_retired, 19);
        chk("bp_evt", 32'(o_halt_evt), 1);
        tick(1, CMD_RUN, 0, 32'h13);
        idle(4);
        settle();
        chk("resume_running", 32'(o_halted), 0);
        chk("resume_retired", o_retired, 23);
        tick(1, CMD_HALT, 0, 32'h13);
        settle();
        chk("host_cause", 32'(o_halt_cause), 32'(CAUSE_HOST));
        chk("host_retired", o_retired, 24);

        tick(1, CMD_RUN, 0, 32'h13);
        idle(1);
        tick(0, CMD_NOP, 0, 32'h0010_0073);
        chk("ebrk_no_commit", 32'(o_core_en), 0);
        settle();
        chk("ebrk_cause", 32'(o_halt_cause), 32'(CAUSE_EBREAK));
        chk("ebrk_retired", o_retired, 25);

        curPc = 32'h3c;
        tick(1, CMD_RUN, 0, 32'h13);
        idle(1);
        tick(1, CMD_HALT, 0, 32'h13);
        settle();
        chk("bp_host_cause", 32'(o_halt_cause), 32'(CAUSE_BP));
        chk("bp_host_evt", 32'(o_halt_evt), 1);
        idle(1);

        tick(1, CMD_STEP, 0, 32'h13);
        idle(3);
        settle();
        chk("step0_retired", o_retired, 27);

        tick(1, CMD_STEP, 10, 32'h13);
        idle(4);
        cyc(1, 0, CMD_NOP, 0, 0, curPc, 32'h13);
        settle();
        chk("rst_mid_retired", o_retired, 0);
        chk("rst_mid_halted", 32'(o_halted), 1);
        idle(3);
        curPc = 32'h3c;
        tick(1, CMD_RUN, 0, 32'h13);
        idle(4);
        settle();
        chk("bp_cleared_running", 32'(o_halted), 0);

        for (int n = 0; n < 3000; n++) begin
            bit          rst, v;
            logic [2:0]  op, idx;
            logic [31:0] arg, pc, inst;
            rst  = ($urandom_range(0, 299) == 0);
            v    = ($urandom_range(0, 3) == 0);
            op   = 3'($urandom_range(0, 7));
            idx  = 3'($urandom_range(0, 7));
            arg  = (op == CMD_STEP) ? 32'($urandom_range(0, 5))
                                    : (32'($urandom_range(0, 16)) << 2) | 32'($urandom_range(0, 3));
            pc   = 32'($urandom_range(0, 16)) << 2;
            inst = ($urandom_range(0, 15) == 0) ? 32'h0010_0073 : $urandom;
            cyc(rst, v, op, idx, arg, pc, inst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
